imem_loader: RTL and testbench

Program loader for the 16-bit processor's 1K x 16 memory. It accepts a stream of instruction words over a valid/ready handshake and writes them into memory from address 0 on the memory's `addr`/`din`/`wea` write port. It then reads the image back through `douta` and compares a 16-bit modular checksum of the readback against the checksum of the written words. While it runs, it holds the CPU off the memory.

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Word-stream and memory-port bundle for the instruction memory loader.
//   slave  : the loader side. It receives in_valid/in_data/douta and drives
//            in_ready plus the memory write port (addr/din/wea).
//   master : the environment side. This is the word source together with the
//            1K x 16 memory that returns douta.
interface imem_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              wea;
    logic [DATA_W-1:0] douta;

    modport master (
        output in_valid, in_data, douta,
        input  in_ready, addr, din, wea
    );

    modport slave (
        input  in_valid, in_data, douta,
        output in_ready, addr, din, wea
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader for the processor's 1K x 16 instruction memory.
// It streams words over a valid/ready handshake into the memory starting at
// address 0. It then reads the image back and compares a 16-bit modular
// checksum of the readback against the checksum of the written words.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   start, len   : load request (sampled only in IDLE), word count (clamped to 2^ADDR_W)
//   bus          : word stream (in_valid/in_data/in_ready) and memory port
//                  (addr/din/wea out, douta in)
//   cpu_hold     : high while a load is in progress
//   done         : one-cycle end-of-load pulse
//   error        : sticky readback checksum mismatch
//   checksum     : modular sum of the written words
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    imem_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {IDLE, WRITE, FLUSH, VERIFY, FINISH} state_t;

    localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_L   = 1;
    localparam logic [ADDR_W-1:0] ONE_A   = 1;

    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] n);
        return (n > MAX_LEN) ? MAX_LEN : n;
    endfunction

    // Modular 16-bit (DATA_W) sum; the carry out is deliberately dropped.
    function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    state_t              state;
    logic [ADDR_W:0]     len_l;
    logic [ADDR_W-1:0]   wptr;
    logic [ADDR_W-1:0]   rptr;
    logic [ADDR_W:0]     smp_cnt;
    logic [DATA_W-1:0]   rb_sum;
    logic                in_ready_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   din_r;
    logic                wea_r;
    // vld_p[0] marks a read address on the bus this cycle; vld_p[RD_LAT]
    // marks the cycle in which that address's douta is valid.
    logic [RD_LAT:0]     vld_p;

    assign bus.in_ready = in_ready_r;
    assign bus.addr     = addr_r;
    assign bus.din      = din_r;
    assign bus.wea      = wea_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_l      <= '0;
            wptr       <= '0;
            rptr       <= '0;
            smp_cnt    <= '0;
            rb_sum     <= '0;
            in_ready_r <= 1'b0;
            addr_r     <= '0;
            din_r      <= '0;
            wea_r      <= 1'b0;
            vld_p      <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            checksum   <= '0;
        end else begin
            wea_r <= 1'b0;
            done  <= 1'b0;
            // Read-tag pipeline: advances every cycle, fed by vld_p[0].
            vld_p[RD_LAT:1] <= vld_p[RD_LAT-1:0];

            case (state)
                IDLE: begin
                    if (start) begin
                        wptr     <= '0;
                        rptr     <= '0;
                        smp_cnt  <= '0;
                        rb_sum   <= '0;
                        checksum <= '0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        if (len == '0) begin
                            // Empty load: straight to the end pulse.
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            len_l      <= clamp_len(len);
                            in_ready_r <= 1'b1;
                            state      <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (bus.in_valid && in_ready_r) begin
                        wea_r    <= 1'b1;
                        addr_r   <= wptr;
                        din_r    <= bus.in_data;
                        checksum <= csum_add(checksum, bus.in_data);
                        wptr     <= wptr + ONE_A;
                        if ({1'b0, wptr} == len_l - ONE_L) begin
                            in_ready_r <= 1'b0;
                            state      <= FLUSH;
                        end
                    end
                end

                // Last write is on the bus this cycle; the first read follows.
                FLUSH: begin
                    addr_r   <= '0;
                    rptr     <= ONE_A;
                    vld_p[0] <= 1'b1;
                    state    <= VERIFY;
                end

                VERIFY: begin
                    // Issue side: one address per cycle until address L-1 is out.
                    if (vld_p[0] && ({1'b0, addr_r} != len_l - ONE_L)) begin
                        addr_r   <= rptr;
                        rptr     <= rptr + ONE_A;
                        vld_p[0] <= 1'b1;
                    end else begin
                        vld_p[0] <= 1'b0;
                    end
                    // Return side: accumulate tagged douta samples.
                    if (vld_p[RD_LAT]) begin
                        rb_sum  <= csum_add(rb_sum, bus.douta);
                        smp_cnt <= smp_cnt + ONE_L;
                        if (smp_cnt + ONE_L == len_l) begin
                            done  <= 1'b1;
                            error <= (csum_add(rb_sum, bus.douta) != checksum);
                            state <= FINISH;
                        end
                    end
                end

                FINISH: begin
                    cpu_hold <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader. The driver pushes the expected memory
// writes and done records as it issues words. A negedge monitor pops them
// whenever the DUT shows wea or done.
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 1;

    typedef struct {
        int a;
        int d;
        int c;
    } rec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] checksum;
    logic              flip_en = 1'b0;

    imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 1K x 16 memory with one-cycle read latency.
    logic [DATA_W-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.wea) mem[bus.addr] <= bus.din;
        bus.douta <= mem[bus.addr] ^ ((flip_en && bus.addr == 2) ? 16'h0001 : 16'h0000);
    end

    int nchk = 0;
    int nfail = 0;
    rec_t wr_q[$];
    rec_t done_q[$];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or done.
    always @(negedge clk) begin
        if (bus.wea) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                rec_t w;
                w = wr_q.pop_front();
                chk("wr_addr", int'(bus.addr), w.a);
                chk("wr_data", int'(bus.din), w.d);
                chk("wr_cycle", cyc, w.c);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                rec_t e;
                e = done_q.pop_front();
                chk("done_checksum", int'(checksum), e.a);
                chk("done_error", int'(error), e.d);
                chk("done_cycle", cyc, e.c);
            end
        end
    end

    int c0 = 0;
    int last_acc = 0;
    int wr_idx = 0;
    logic [DATA_W-1:0] model_sum = '0;

    task automatic start_load(input int n);
        start = 1'b1;
        len = n[ADDR_W:0];
        c0 = cyc;
        model_sum = '0;
        wr_idx = 0;
        if (n == 0) done_q.push_back('{0, 0, c0 + 1});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] w, input int gap, input bit last,
                        input int nl, input int exp_err);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data = w;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        wr_q.push_back('{wr_idx, int'(w), cyc + 1});
        wr_idx++;
        model_sum += w;
        last_acc = cyc;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        if (last) begin
            chk("in_ready_drop", int'(bus.in_ready), 0);
            done_q.push_back('{int'(model_sum), exp_err, last_acc + nl + 2 + RD_LAT});
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((done_q.size() != 0 || cpu_hold) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 3000) chk("load_timeout", 0, 1);
    endtask

    task automatic load4(input int gap, input int exp_err);
        start_load(4);
        send(16'h1234, gap, 1'b0, 4, exp_err);
        send(16'h0001, gap, 1'b0, 4, exp_err);
        send(16'hFFFF, gap, 1'b0, 4, exp_err);
        send(16'h8000, 0, 1'b1, 4, exp_err);
        wait_idle();
    endtask

    task automatic check_image4(input string tag);
        chk({tag, "_mem0"}, int'(mem[0]), 'h1234);
        chk({tag, "_mem1"}, int'(mem[1]), 'h0001);
        chk({tag, "_mem2"}, int'(mem[2]), 'hFFFF);
        chk({tag, "_mem3"}, int'(mem[3]), 'h8000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit any_hold;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_addr", int'(bus.addr), 0);
        chk("rst_din", int'(bus.din), 0);
        chk("rst_wea", int'(bus.wea), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_cpu_hold", int'(cpu_hold), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_checksum", int'(checksum), 0);
        any_hold = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 any_hold |= cpu_hold;
        end
        chk("idle_cpu_hold", int'(any_hold), 0);

        // Continuous 4-word load.
        load4(0, 0);
        chk("l4_checksum", int'(checksum), 'h9234);
        chk("l4_error", int'(error), 0);
        check_image4("l4");

        // Same load with a gap after every word.
        load4(1, 0);
        chk("gap_checksum", int'(checksum), 'h9234);
        check_image4("gap");

        // Corrupted readback at address 2.
        flip_en = 1'b1;
        load4(0, 1);
        chk("err_sticky", int'(error), 1);
        flip_en = 1'b0;

        // Empty load; also clears the previous error.
        start_load(0);
        chk("len0_error_cleared", int'(error), 0);
        chk("len0_cpu_hold", int'(cpu_hold), 1);
        wait_idle();
        chk("len0_checksum", int'(checksum), 0);

        // Oversized load, clamped to 1024 words.
        start_load(2000);
        for (int i = 0; i < 1024; i++)
            send(DATA_W'(i * 37 + 5), 0, i == 1023, 1024, 0);
        wait_idle();
        chk("big_error", int'(error), 0);
        chk("big_mem1023", int'(mem[1023]), (1023 * 37 + 5) & 'hFFFF);
        chk("big_mem0", int'(mem[0]), 5);

        // Reset right after the second accept aborts the load.
        start_load(4);
        send(16'hAAAA, 0, 1'b0, 4, 0);
        send(16'h5555, 0, 1'b0, 4, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_wea", int'(bus.wea), 0);
        chk("abort_cpu_hold", int'(cpu_hold), 0);
        chk("abort_in_ready", int'(bus.in_ready), 0);
        chk("abort_done", int'(done), 0);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        load4(0, 0);
        chk("after_abort_checksum", int'(checksum), 'h9234);
        chk("after_abort_error", int'(error), 0);

        repeat (5) @(posedge clk);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end
endmodule
